emu_time_mgr: RTL and testbench
===============================

# emu_time_mgr

Emulator timestep manager, directly upstream of the oscillator stage. Collects the per-block timestep requests (`dt_req`), selects the smallest enabled request, and returns it to every block as the shared `emu_dt`. Keeps the global emulated time, counts emulation steps, and stops the emulation exactly at a programmed stop time. `emu_dt` is combinational from the requests in the same cycle, because requesters consume it in the cycle they issue the request. All time state is registered.

## Interface
- `N_REQ`, default 2: number of timestep requesters.
- `DT_WIDTH`, default 27: width of each request and of `emu_dt`. Unsigned fixed-point; matches the system `DT_WIDTH`.
- `TIME_WIDTH`, default 39: width of `emu_time` and `t_stop`. Unsigned, same LSB weight as `dt`.
- `DT_MAX`, default 2^DT_WIDTH-1: cap on any step.
- `emu_clk`  in  1  emulator clock. This is the block's only clock.
- `emu_rst`  in  1  reset, asynchronous, active-low.
- `dt_req`  in  N_REQ*DT_WIDTH  packed requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- `req_en`  in  N_REQ  per-requester enable. A disabled request is ignored.
- `start`  in  1  single-cycle pulse that begins or resumes stepping.
- `t_stop`  in  TIME_WIDTH  stop time. Sampled every cycle.
- `emu_dt`  out  DT_WIDTH  granted step for this cycle (combinational).
- `emu_time`  out  TIME_WIDTH  accumulated emulated time (registered).
- `step_cnt`  out  32  number of cycles with nonzero `emu_dt`. Wraps at 2^32.
- `running`  out  1  high in state RUN.
- `done`  out  1  high in state HALT.

## Operation
- States: IDLE, RUN, HALT. Reset state is IDLE.
- Reset values: `emu_time`=0, `step_cnt`=0, `running`=0, `done`=0, `emu_dt`=0.
- Candidate step `dt_min`:
  - `dt_min` is the minimum of `DT_MAX` and every `dt_req[i]` with `req_en[i]`=1.
  - If no requester is enabled, `dt_min` = `DT_MAX`.
  - Ties need no resolution; only the value matters.
- Remaining time: `t_rem = t_stop - emu_time`. It is computed in TIME_WIDTH+1 bits, and a negative result is treated as 0.
- Output step:
  - In RUN: `emu_dt = min(dt_min, t_rem)`. `t_rem` is truncated to DT_WIDTH only when it is below 2^DT_WIDTH; otherwise `dt_min` wins.
  - In IDLE and HALT: `emu_dt` = 0.
- Each RUN cycle: `emu_time <= emu_time + emu_dt`. If `emu_dt`≠0, `step_cnt <= step_cnt + 1`.
- Transitions:
  - IDLE→RUN on `start` when `t_stop > emu_time`.
  - IDLE→HALT on `start` when `t_stop <= emu_time`.
  - RUN→HALT when `emu_time + emu_dt >= t_stop`, i.e. the current step lands exactly on `t_stop`. This includes `t_rem`=0 caused by `t_stop` being lowered mid-run.
  - HALT→RUN on `start` when `t_stop > emu_time`, so raising `t_stop` extends a run. Otherwise HALT stays.
  - `start` while in RUN is ignored.
- A zero request from an enabled requester gives `emu_dt`=0. The state stays RUN, `emu_time` holds and `step_cnt` holds. This is legal stalling.
- `emu_time` never exceeds `t_stop`. Overflow past 2^TIME_WIDTH is impossible by construction.
- Asserting `emu_rst` mid-operation clears all state immediately, regardless of `emu_clk`.

## Timing
- `dt_req`/`req_en`/`t_stop` → `emu_dt`: 0 cycles (combinational, same cycle).
- `emu_dt` → `emu_time`: visible 1 cycle later.
- `start` → `running`: `running` rises the cycle after the `start` edge. `emu_dt` is nonzero from that cycle.
- The final step and the `done` rise:
  - The final step is issued in the last RUN cycle.
  - `done` rises in the next cycle, with `emu_time == t_stop`. `emu_dt` is 0 in that cycle.
- The min tree is log2(N_REQ) comparator levels. It must close at the emulator clock; it has no pipelining.

## Test plan
- **Basic min selection:** N_REQ=2, `req_en`=11, `dt_req`={50,30}, `t_stop`=1000, `start`.
  - `emu_dt`=30 each cycle.
  - `emu_time` reads 30, 60, 90…
  - `step_cnt` increments by 1 per cycle.
- **Masking:**
  - `req_en`=01 with `dt_req`={5,40} → `emu_dt`=40.
  - `req_en`=00 → `emu_dt`=`DT_MAX`. Check with `DT_MAX` set to 100 → 100.
- **Exact stop:** `dt_req`=30 for both requesters, `t_stop`=100.
  - Steps are 30, 30, 30, 10.
  - Then `done`=1, `running`=0, `emu_time`=100, `emu_dt`=0 held.
- **Stop already passed:** after a run ending at 100, set `t_stop`=80, `start`.
  - The block goes to HALT.
  - `emu_dt` stays 0 and `emu_time` stays 100.
- **Extend:** in HALT, set `t_stop`=160, `start`.
  - RUN resumes with steps 30, 30.
  - HALT follows with `emu_time`=160 and `step_cnt` = previous count + 2.
- **Stall and async reset:**
  - An enabled requester at 0 gives `emu_dt`=0 while `running`=1, and `emu_time`/`step_cnt` hold.
  - Pulling `emu_rst` low between clock edges zeroes all outputs immediately and returns the block to IDLE.

Source files
------------

// File: rtl/emu_time_mgr.sv
// Emulator timestep manager: grants the smallest enabled timestep request,
// accumulates emulated time and halts exactly on the programmed stop time.
module emu_time_mgr #(
    parameter int                  N_REQ      = 2,
    parameter int                  DT_WIDTH   = 27,
    parameter int                  TIME_WIDTH = 39,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = '1
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          req_en,
    input  logic                      start,
    input  logic [TIME_WIDTH-1:0]     t_stop,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [31:0]               step_cnt,
    output logic                      running,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam int LEVELS = $clog2(N_REQ);
    localparam int LEAVES = 1 << LEVELS;

    state_t                state_reg;
    logic [TIME_WIDTH-1:0] time_reg;
    logic [31:0]           cnt_reg;
    logic                  running_reg;
    logic                  done_reg;

    logic [DT_WIDTH-1:0]   dt_min;
    logic [TIME_WIDTH:0]   diff;
    logic [TIME_WIDTH-1:0] t_rem;
    logic                  rem_fits;
    logic [DT_WIDTH-1:0]   dt_run;
    logic [TIME_WIDTH-1:0] time_next;
    logic                  lands;
    logic                  start_ok;

    // Balanced min tree; unused or disabled leaves are padded with DT_MAX so
    // the root is already capped.
    generate
        for (genvar gi = 0; gi <= LEVELS; gi++) begin : lvl_g
            localparam int W = LEAVES >> gi;
            logic [DT_WIDTH-1:0] val [W];
            for (genvar gj = 0; gj < W; gj++) begin : node_g
                if (gi == 0) begin : leaf_g
                    if (gj < N_REQ) begin : used_g
                        assign val[gj] = (req_en[gj] && (dt_req[gj*DT_WIDTH +: DT_WIDTH] < DT_MAX))
                                         ? dt_req[gj*DT_WIDTH +: DT_WIDTH] : DT_MAX;
                    end else begin : pad_g
                        assign val[gj] = DT_MAX;
                    end
                end else begin : cmp_g
                    assign val[gj] = (lvl_g[gi-1].val[2*gj] < lvl_g[gi-1].val[2*gj+1])
                                     ? lvl_g[gi-1].val[2*gj] : lvl_g[gi-1].val[2*gj+1];
                end
            end
        end
    endgenerate

    assign dt_min = lvl_g[LEVELS].val[0];

    // Negative remaining time (stop lowered below current time) clamps to 0.
    assign diff     = {1'b0, t_stop} - {1'b0, time_reg};
    assign t_rem    = diff[TIME_WIDTH] ? '0 : diff[TIME_WIDTH-1:0];
    assign rem_fits = ~|t_rem[TIME_WIDTH-1:DT_WIDTH];
    assign dt_run   = (rem_fits && (t_rem[DT_WIDTH-1:0] < dt_min)) ? t_rem[DT_WIDTH-1:0] : dt_min;
    assign emu_dt   = (state_reg == RUN) ? dt_run : '0;

    // emu_dt never exceeds t_rem, so this sum cannot overflow.
    assign time_next = time_reg + {{(TIME_WIDTH-DT_WIDTH){1'b0}}, emu_dt};
    assign lands     = time_next >= t_stop;
    assign start_ok  = t_stop > time_reg;

    always_ff @(posedge emu_clk or negedge emu_rst) begin
        if (!emu_rst) begin
            state_reg   <= IDLE;
            time_reg    <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end else begin
                            state_reg <= HALT;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    time_reg <= time_next;
                    if (emu_dt != '0) begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                    if (lands) begin
                        state_reg   <= HALT;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                HALT: begin
                    if (start && start_ok) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign emu_time = time_reg;
    assign step_cnt = cnt_reg;
    assign running  = running_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_emu_time_mgr.sv
// Directed bench for emu_time_mgr: min selection, masking, exact stop,
// resume/extend, stalling and asynchronous reset.
module tb_emu_time_mgr;

    localparam int DW = 27;
    localparam int TW = 39;

    logic            emu_clk = 1'b0;
    logic            emu_rst = 1'b0;
    logic [2*DW-1:0] dt_req  = '0;
    logic [1:0]      req_en  = '0;
    logic            start   = 1'b0;
    logic [TW-1:0]   t_stop  = '0;
    logic [DW-1:0]   emu_dt;
    logic [TW-1:0]   emu_time;
    logic [31:0]     step_cnt;
    logic            running;
    logic            done;

    int errors = 0;
    int checks = 0;

    emu_time_mgr #(.N_REQ(2), .DT_WIDTH(DW), .TIME_WIDTH(TW), .DT_MAX(27'd100)) dut (
        .emu_clk (emu_clk),
        .emu_rst (emu_rst),
        .dt_req  (dt_req),
        .req_en  (req_en),
        .start   (start),
        .t_stop  (t_stop),
        .emu_dt  (emu_dt),
        .emu_time(emu_time),
        .step_cnt(step_cnt),
        .running (running),
        .done    (done)
    );

    // Posedges at 5 mod 10; inputs change on negedges at 0 mod 10.
    always #5 emu_clk = ~emu_clk;

    task automatic set_req(input logic [DW-1:0] r1, input logic [DW-1:0] r0, input logic [1:0] en);
        dt_req = {r1, r0};
        req_en = en;
    endtask

    task automatic pulse_start();
        @(negedge emu_clk);
        start = 1'b1;
        @(negedge emu_clk);
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        emu_rst = 1'b0;
        set_req(27'd7, 27'd9, 2'b11);
        t_stop = 39'd500;
        #23;
        checks++; if (emu_dt !== 27'd0)   begin errors++; $display("FAIL reset_dt got=%0d exp=0", emu_dt); end
        checks++; if (emu_time !== 39'd0) begin errors++; $display("FAIL reset_time got=%0d exp=0", emu_time); end
        checks++; if (step_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", step_cnt); end
        checks++; if ({running, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {running, done}); end
        @(negedge emu_clk);
        emu_rst = 1'b1;
        @(negedge emu_clk);
        #1;
        checks++; if (emu_dt !== 27'd0) begin errors++; $display("FAIL idle_dt got=%0d exp=0", emu_dt); end
        $display("reset: dt=%0d time=%0d cnt=%0d", emu_dt, emu_time, step_cnt);
    endtask

    task automatic test_basic_min();
        set_req(27'd50, 27'd30, 2'b11);
        t_stop = 39'd1000;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            checks++; if (emu_dt !== 27'd30) begin errors++; $display("FAIL basic_dt[%0d] got=%0d exp=30", k, emu_dt); end
            checks++; if (emu_time !== TW'(30*k)) begin errors++; $display("FAIL basic_time[%0d] got=%0d exp=%0d", k, emu_time, 30*k); end
            checks++; if (step_cnt !== 32'(k)) begin errors++; $display("FAIL basic_cnt[%0d] got=%0d exp=%0d", k, step_cnt, k); end
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running[%0d] got=%b exp=1", k, running); end
            $display("basic step %0d: dt=%0d time=%0d cnt=%0d", k, emu_dt, emu_time, step_cnt);
            @(negedge emu_clk);
            #1;
        end
    endtask

    task automatic test_masking();
        set_req(27'd5, 27'd40, 2'b01);
        #1;
        checks++; if (emu_dt !== 27'd40) begin errors++; $display("FAIL mask_01 got=%0d exp=40", emu_dt); end
        set_req(27'd5, 27'd40, 2'b10);
        #1;
        checks++; if (emu_dt !== 27'd5) begin errors++; $display("FAIL mask_10 got=%0d exp=5", emu_dt); end
        set_req(27'd5, 27'd40, 2'b00);
        #1;
        checks++; if (emu_dt !== 27'd100) begin errors++; $display("FAIL mask_00 got=%0d exp=100", emu_dt); end
        set_req(27'd500, 27'd300, 2'b11);
        #1;
        checks++; if (emu_dt !== 27'd100) begin errors++; $display("FAIL mask_cap got=%0d exp=100", emu_dt); end
        $display("masking: dt with all disabled=%0d", emu_dt);
        emu_rst = 1'b0;
        #2;
        emu_rst = 1'b1;
    endtask

    task automatic test_exact_stop();
        logic [DW-1:0] exp_dt [4] = '{27'd30, 27'd30, 27'd30, 27'd10};
        set_req(27'd30, 27'd30, 2'b11);
        t_stop = 39'd100;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            checks++; if (emu_dt !== exp_dt[k]) begin errors++; $display("FAIL stop_dt[%0d] got=%0d exp=%0d", k, emu_dt, exp_dt[k]); end
            checks++; if (emu_time !== TW'(30*k)) begin errors++; $display("FAIL stop_time[%0d] got=%0d exp=%0d", k, emu_time, 30*k); end
            $display("stop step %0d: dt=%0d time=%0d", k, emu_dt, emu_time);
            @(negedge emu_clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            checks++; if ({running, done} !== 2'b01) begin errors++; $display("FAIL stop_flags[%0d] got=%b exp=01", k, {running, done}); end
            checks++; if (emu_time !== 39'd100) begin errors++; $display("FAIL stop_hold_time[%0d] got=%0d exp=100", k, emu_time); end
            checks++; if (emu_dt !== 27'd0) begin errors++; $display("FAIL stop_hold_dt[%0d] got=%0d exp=0", k, emu_dt); end
            @(negedge emu_clk);
            #1;
        end
        checks++; if (step_cnt !== 32'd4) begin errors++; $display("FAIL stop_cnt got=%0d exp=4", step_cnt); end
    endtask

    task automatic test_stop_passed();
        t_stop = 39'd80;
        pulse_start();
        checks++; if ({running, done} !== 2'b01) begin errors++; $display("FAIL passed_flags got=%b exp=01", {running, done}); end
        checks++; if (emu_dt !== 27'd0) begin errors++; $display("FAIL passed_dt got=%0d exp=0", emu_dt); end
        @(negedge emu_clk);
        #1;
        checks++; if (emu_time !== 39'd100) begin errors++; $display("FAIL passed_time got=%0d exp=100", emu_time); end
        $display("stop passed: time=%0d done=%b", emu_time, done);
    endtask

    task automatic test_extend();
        t_stop = 39'd160;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            checks++; if (emu_dt !== 27'd30) begin errors++; $display("FAIL ext_dt[%0d] got=%0d exp=30", k, emu_dt); end
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL ext_running[%0d] got=%b exp=1", k, running); end
            checks++; if (emu_time !== TW'(100 + 30*k)) begin errors++; $display("FAIL ext_time[%0d] got=%0d exp=%0d", k, emu_time, 100 + 30*k); end
            $display("extend step %0d: dt=%0d time=%0d", k, emu_dt, emu_time);
            @(negedge emu_clk);
            #1;
        end
        checks++; if ({running, done} !== 2'b01) begin errors++; $display("FAIL ext_flags got=%b exp=01", {running, done}); end
        checks++; if (emu_time !== 39'd160) begin errors++; $display("FAIL ext_end_time got=%0d exp=160", emu_time); end
        checks++; if (step_cnt !== 32'd6) begin errors++; $display("FAIL ext_cnt got=%0d exp=6", step_cnt); end
    endtask

    task automatic test_stall_and_reset();
        set_req(27'd30, 27'd0, 2'b11);
        t_stop = 39'd300;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            checks++; if (emu_dt !== 27'd0) begin errors++; $display("FAIL stall_dt[%0d] got=%0d exp=0", k, emu_dt); end
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL stall_running[%0d] got=%b exp=1", k, running); end
            checks++; if (emu_time !== 39'd160 || step_cnt !== 32'd6) begin
                errors++; $display("FAIL stall_hold[%0d] got time=%0d cnt=%0d exp time=160 cnt=6", k, emu_time, step_cnt);
            end
            $display("stall cycle %0d: dt=%0d time=%0d cnt=%0d", k, emu_dt, emu_time, step_cnt);
            @(negedge emu_clk);
            #1;
        end
        set_req(27'd30, 27'd20, 2'b11);
        #1;
        checks++; if (emu_dt !== 27'd20) begin errors++; $display("FAIL unstall_dt got=%0d exp=20", emu_dt); end
        @(negedge emu_clk);
        #1;
        checks++; if (emu_time !== 39'd180 || step_cnt !== 32'd7) begin
            errors++; $display("FAIL unstall_state got time=%0d cnt=%0d exp time=180 cnt=7", emu_time, step_cnt);
        end
        // Lowering t_stop onto the current time forces a zero final step.
        t_stop = 39'd180;
        #1;
        checks++; if (emu_dt !== 27'd0) begin errors++; $display("FAIL lowered_dt got=%0d exp=0", emu_dt); end
        @(negedge emu_clk);
        #1;
        checks++; if ({running, done} !== 2'b01) begin errors++; $display("FAIL lowered_flags got=%b exp=01", {running, done}); end
        // Async reset pulled mid-cycle, away from any clock edge.
        #1;
        emu_rst = 1'b0;
        #1;
        checks++; if (emu_time !== 39'd0 || step_cnt !== 32'd0) begin
            errors++; $display("FAIL async_state got time=%0d cnt=%0d exp 0", emu_time, step_cnt);
        end
        checks++; if ({running, done} !== 2'b00 || emu_dt !== 27'd0) begin
            errors++; $display("FAIL async_outputs got flags=%b dt=%0d exp flags=00 dt=0", {running, done}, emu_dt);
        end
        @(negedge emu_clk);
        emu_rst = 1'b1;
        @(negedge emu_clk);
        #1;
        checks++; if (running !== 1'b0 || emu_dt !== 27'd0 || emu_time !== 39'd0) begin
            errors++; $display("FAIL post_reset_idle got running=%b dt=%0d time=%0d exp 0", running, emu_dt, emu_time);
        end
        $display("async reset: time=%0d cnt=%0d running=%b done=%b", emu_time, step_cnt, running, done);
    endtask

    initial begin
        test_reset();
        test_basic_min();
        test_masking();
        test_exact_stop();
        test_stop_passed();
        test_extend();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
